// File: rtl/ser_frame_ctrl.sv
// Serial frame controller: sends a latched frame MSB-first into a sequence detector and captures its replies.
// Optional build macro SER_FRAME_CTRL_STEP_EN enables single-step gating through i_step_mode / i_step.
//   state   | meaning
//   S_IDLE  | waiting for i_start
//   S_CLR   | one-cycle detector reset, frame latched, capture cleared
//   S_SEND  | one frame bit per enabled cycle
//   S_DRAIN | flush detector until valid falls or the drain timer expires
//   S_DONE  | one-cycle done pulse
module ser_frame_ctrl #(
    parameter int FRAME_W   = 16,
    parameter int DRAIN_MAX = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_frame_in,
    input  logic [4:0]         i_frame_len,
    input  logic               i_step_mode,
    input  logic               i_step,
    input  logic               i_det_serOut,
    input  logic               i_det_serOutValid,
    output logic               o_det_rst,
    output logic               o_det_Clk_EN,
    output logic               o_det_serIn,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    output logic [FRAME_W-1:0] o_rx_data,
    output logic [4:0]         o_rx_count
);
    localparam int CW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_SEND, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [FRAME_W-1:0] r_shift;
    logic [4:0]         r_bits_left;
    logic [CW-1:0]      r_drain_cnt;
    logic               r_seen;
    logic               r_ser_in;
    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic [FRAME_W-1:0] r_rx_data;
    logic [4:0]         r_rx_count;

    logic [4:0]         w_eff_len;
    logic [FRAME_W-1:0] w_frame_aligned;
    logic               w_gate;
    logic               w_en;
    logic               w_capture;
    logic               w_room;

`ifdef SER_FRAME_CTRL_STEP_EN
    assign w_gate = ~i_step_mode | i_step;
`else
    logic w_unused_step;
    assign w_unused_step = i_step_mode ^ i_step;
    assign w_gate = 1'b1;
`endif

    assign w_eff_len = ((i_frame_len == 5'd0) || (int'(i_frame_len) > FRAME_W))
                       ? 5'(FRAME_W) : i_frame_len;
    // Left-align the frame so the first bit to send always sits in the MSB.
    assign w_frame_aligned = i_frame_in << (5'(FRAME_W) - w_eff_len);

    assign w_en      = ~i_rst & ((r_state == S_SEND) | (r_state == S_DRAIN)) & w_gate;
    assign w_capture = w_en & i_det_serOutValid;
    assign w_room    = r_rx_count < 5'(FRAME_W);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_drain_cnt <= '0;
            r_seen      <= 1'b0;
            r_ser_in    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_rx_data   <= '0;
            r_rx_count  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_seen <= 1'b1;
                if (w_room) begin
                    r_rx_data  <= {r_rx_data[FRAME_W-2:0], i_det_serOut};
                    r_rx_count <= r_rx_count + 5'd1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_CLR;
                        r_busy      <= 1'b1;
                        r_shift     <= w_frame_aligned;
                        r_bits_left <= w_eff_len;
                        r_rx_data   <= '0;
                        r_rx_count  <= '0;
                        r_timeout   <= 1'b0;
                        r_seen      <= 1'b0;
                    end
                end
                S_CLR: begin
                    r_state     <= S_SEND;
                    r_ser_in    <= r_shift[FRAME_W-1];
                    r_drain_cnt <= CW'(DRAIN_MAX);
                end
                S_SEND: begin
                    if (w_en) begin
                        r_shift     <= r_shift << 1;
                        r_bits_left <= r_bits_left - 5'd1;
                        if (r_bits_left == 5'd1) begin
                            r_state  <= S_DRAIN;
                            r_ser_in <= 1'b0;
                        end else begin
                            r_ser_in <= r_shift[FRAME_W-2];
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_en) begin
                        // A falling valid wins over an expiring timer in the same cycle.
                        if (r_seen && !i_det_serOutValid) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (r_drain_cnt == CW'(1)) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_det_rst    = i_rst | (r_state == S_CLR);
    assign o_det_Clk_EN = w_en;
    assign o_det_serIn  = r_ser_in;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;
    assign o_rx_data    = r_rx_data;
    assign o_rx_count   = r_rx_count;
endmodule

// File: doc/ser_frame_ctrl.md
SER_FRAME_CTRL -- requirements
Module: ser_frame_ctrl

Interface
REQ-001 Parameter FRAME_W, default 16, SHALL set the maximum frame length in bits.
REQ-002 Parameter DRAIN_MAX, default 32, SHALL set the maximum number of enabled drain cycles before timeout.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 start  in  1  SHALL request one frame transfer; sampled only in IDLE.
REQ-006 frame_in  in  FRAME_W  SHALL carry the pattern to send, MSB first.
REQ-007 frame_len  in  5  SHALL give the bit count; 0 or values above FRAME_W mean FRAME_W.
REQ-008 step_mode, step  in  1,1  SHALL select single-step mode and supply the step pulse.
REQ-009 det_serOut, det_serOutValid  in  1,1  SHALL carry serial data and valid from the sequence detector.
REQ-010 det_rst, det_Clk_EN, det_serIn  out  1,1,1  SHALL drive the detector's reset, clock enable and serial input.
REQ-011 busy, done, timeout  out  1,1,1  SHALL report status; done is a one-cycle pulse.
REQ-012 rx_data, rx_count  out  FRAME_W,5  SHALL hold captured bits (LSB = latest) and the captured-bit count.

Function
REQ-013 The FSM SHALL have states IDLE, CLR, SEND, DRAIN and DONE.
REQ-014 IDLE SHALL move to CLR on start=1; start outside IDLE SHALL be ignored.
REQ-015 CLR SHALL last exactly one cycle, with det_rst=1 and rx_data, rx_count and timeout cleared; then go to SEND.
REQ-016 On entering CLR, frame_in and the effective length SHALL be latched; later input changes SHALL not affect the frame.
REQ-017 SEND SHALL drive det_serIn with the next latched bit, MSB first, and advance one bit per enabled cycle.
REQ-018 An enabled cycle SHALL be:
- any SEND/DRAIN cycle when step_mode=0;
- a SEND/DRAIN cycle with step=1 when step_mode=1.
REQ-019 det_Clk_EN SHALL equal the enabled-cycle condition; it SHALL be 0 in IDLE, CLR and DONE.
REQ-020 Latency: start at cycle t (step_mode=0) SHALL put CLR at t+1 and the first bit on det_serIn at t+2.
REQ-021 After the last bit's enabled cycle, the FSM SHALL enter DRAIN, with det_serIn=0.
REQ-022 DRAIN SHALL exit to DONE on the first enabled cycle where det_serOutValid=0 after valid has been 1 at least once since CLR.
REQ-023 DRAIN SHALL also exit to DONE with timeout=1 after DRAIN_MAX enabled cycles.
REQ-024 In SEND and DRAIN, each enabled cycle with det_serOutValid=1 SHALL:
- shift det_serOut into rx_data LSB;
- increment rx_count.
REQ-025 rx_count SHALL saturate at FRAME_W; further valid bits SHALL be dropped and leave rx_data unchanged.
REQ-026 DONE SHALL assert done for one cycle and return to IDLE; rx_data, rx_count and timeout SHALL hold until the next CLR.
REQ-027 busy SHALL be 1 in CLR, SEND, DRAIN and DONE, and 0 in IDLE.
REQ-028 A step pulse with step_mode=0, or a step in IDLE, SHALL have no effect.

Reset
REQ-029 rst=1 SHALL force IDLE from any state, mid-frame included, on the next edge.
REQ-030 Reset values: det_rst=1 during rst; det_Clk_EN, det_serIn, busy, done, timeout = 0; rx_data, rx_count = 0.
REQ-031 rst SHALL take priority over start, step and every other input in the same cycle.

Configuration
REQ-032 With macro SER_FRAME_CTRL_STEP_EN defined, single-step gating SHALL operate as in REQ-018.
REQ-033 Without SER_FRAME_CTRL_STEP_EN, step_mode and step SHALL be ignored, and every SEND/DRAIN cycle SHALL be enabled.

Verification
REQ-034 Free-run:
- stimulus: step_mode=0, frame_in=16'hAAAA, frame_len=8, start pulse;
- response: det_serIn 1,0,1,0,1,0,1,0 from t+2; done once; busy=0 afterwards.
REQ-035 Capture:
- stimulus: detector model returns valid=1 for 4 cycles with bits 1,0,1,1;
- response: rx_data[3:0]=4'b1011, rx_count=4, timeout=0.
REQ-036 Timeout:
- stimulus: det_serOutValid held 0, frame_len=3;
- response: done exactly 3+DRAIN_MAX enabled cycles after the first SEND cycle; timeout=1; rx_count=0.
REQ-037 Step mode (macro defined):
- stimulus: step_mode=1, step every 10th cycle;
- response: det_Clk_EN high only on step cycles; bit order unchanged.
- Macro undefined: step ignored.
REQ-038 Reset and boundaries:
- rst asserted in SEND after 2 bits -> IDLE next cycle, all outputs at reset values;
- frame_len=0 -> 16 bits sent;
- start asserted while busy -> ignored.
